// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 4-bit combinational ALU: accepts one instruction, drives ALU operands,
// captures the result and writes it back. Define ALU_FLAGS_EN to add the flagZero/flagCarry outputs.
module alu_issue_ctrl #(
    parameter  int DATA_W = 4,
    parameter  int NREG   = 4,
    localparam int IDX_W  = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instValid,
    output logic              instReady,
    input  logic              instLoad,
    input  logic [2:0]        instOp,
    input  logic [IDX_W-1:0]  instDst,
    input  logic [IDX_W-1:0]  instSrcA,
    input  logic [IDX_W-1:0]  instSrcB,
    input  logic [DATA_W-1:0] instImm,
    output logic [DATA_W-1:0] aluA,
    output logic [DATA_W-1:0] aluB,
    output logic [2:0]        aluSel,
    input  logic [DATA_W-1:0] aluOut,
    output logic              wbValid,
    output logic [IDX_W-1:0]  wbDst,
    output logic [DATA_W-1:0] wbData,
    output logic              busy,
`ifdef ALU_FLAGS_EN
    output logic              flagZero,
    output logic              flagCarry,
`endif
    output logic [1:0]        dbg_state
);

    // Handshake: an instruction transfers on a rising edge where instValid and instReady are
    // both high; while instReady is low the upstream holds its instruction and nothing is sampled.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WB    = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [DATA_W-1:0] rf [NREG];
    logic [DATA_W-1:0] res;
    logic [IDX_W-1:0]  dst;
    logic              accept;

    assign accept    = instValid && instReady;
    assign dbg_state = state;
    assign wbDst     = dst;
    assign wbData    = res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = instLoad ? WB : ISSUE;
            ISSUE:   state_nx = WB;
            WB:      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        instReady = (state == IDLE);
        busy      = (state != IDLE);
        wbValid   = (state == WB);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
            res    <= '0;
            dst    <= '0;
            aluA   <= '0;
            aluB   <= '0;
            aluSel <= 3'b000;
        end else begin
            if (accept) begin
                dst <= instDst;
                if (instLoad) begin
                    res <= instImm;
                end else begin
                    aluA   <= rf[instSrcA];
                    aluB   <= rf[instSrcB];
                    aluSel <= instOp;
                end
            end
            if (state == ISSUE) res <= aluOut;
            if (state == WB) rf[dst] <= res;
        end
    end

`ifdef ALU_FLAGS_EN
    logic load_q;
    logic carry_add;
    logic borrow_sub;

    // Carry out of A+B is set exactly when the true sum exceeds the largest DATA_W-bit value.
    assign carry_add  = ({1'b0, aluA} + {1'b0, aluB}) > {1'b0, {DATA_W{1'b1}}};
    assign borrow_sub = (aluA < aluB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_q    <= 1'b0;
            flagZero  <= 1'b0;
            flagCarry <= 1'b0;
        end else begin
            if (accept) load_q <= instLoad;
            if (state == WB) begin
                flagZero <= (res == '0);
                if (!load_q && aluSel == 3'b000) flagCarry <= carry_add;
                if (!load_q && aluSel == 3'b001) flagCarry <= borrow_sub;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized self-checking bench for alu_issue_ctrl with a behavioural ALU and register-file model.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instValid, instReady, instLoad;
  logic [2:0] instOp;
  logic [1:0] instDst, instSrcA, instSrcB;
  logic [3:0] instImm;
  logic [3:0] aluA, aluB, aluOut;
  logic [2:0] aluSel;
  logic       wbValid;
  logic [1:0] wbDst;
  logic [3:0] wbData;
  logic       busy;
  logic [1:0] dbg_state;
`ifdef ALU_FLAGS_EN
  logic       flagZero, flagCarry;
`endif

  int total = 0;
  int bad = 0;

  logic [3:0] model_rf [4];
  logic       model_z, model_c;
  logic [3:0] exp_q [$];
  logic [1:0] dst_q [$];

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .instValid(instValid), .instReady(instReady), .instLoad(instLoad),
    .instOp(instOp), .instDst(instDst), .instSrcA(instSrcA), .instSrcB(instSrcB),
    .instImm(instImm),
    .aluA(aluA), .aluB(aluB), .aluSel(aluSel), .aluOut(aluOut),
    .wbValid(wbValid), .wbDst(wbDst), .wbData(wbData), .busy(busy),
`ifdef ALU_FLAGS_EN
    .flagZero(flagZero), .flagCarry(flagCarry),
`endif
    .dbg_state(dbg_state)
  );

  function automatic logic [3:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    int r;
    case (op)
      3'd0: r = int'(a) + int'(b);
      3'd1: r = int'(a) - int'(b) + 16;
      3'd2: r = int'(a & b);
      3'd3: r = int'(a | b);
      3'd4: r = int'(a ^ b);
      3'd5: r = int'(a) / (1 << b);
      3'd6: r = int'(a) * (1 << b);
      default: r = (a > b) ? 1 : 0;
    endcase
    return r[3:0];
  endfunction

  assign aluOut = alu_fn(aluA, aluB, aluSel);

  task automatic model_op_flags(input logic [2:0] op, input logic [3:0] va, input logic [3:0] vb, input logic [3:0] r);
    model_z = (r == 4'd0);
    if (op == 3'd0) model_c = (int'(va) + int'(vb)) > 15;
    if (op == 3'd1) model_c = va < vb;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (instReady === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL ready_timeout: instReady=%b required 1 within 20 cycles", instReady);
    end
  endtask

  task automatic do_load(input logic [1:0] d, input logic [3:0] imm);
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    instValid = 1'b1; instLoad = 1'b1; instDst = d; instImm = imm;
    instOp = 3'($urandom_range(0, 7)); instSrcA = 2'($urandom_range(0, 3)); instSrcB = 2'($urandom_range(0, 3));
    @(posedge clk); #1 instValid = 1'b0;
    @(negedge clk);
    total++; if (wbValid !== 1'b1) begin bad++; $display("FAIL load_wbvalid: got %b want 1", wbValid); end
    total++; if (wbDst !== d) begin bad++; $display("FAIL load_wbdst: got %0d want %0d", wbDst, d); end
    total++; if (wbData !== imm) begin bad++; $display("FAIL load_wbdata: got %h want %h", wbData, imm); end
    total++; if (instReady !== 1'b0) begin bad++; $display("FAIL load_ready_low: got %b want 0", instReady); end
    model_rf[d] = imm;
    model_z = (imm == 4'd0);
    @(negedge clk);
    total++; if (wbValid !== 1'b0) begin bad++; $display("FAIL load_wb_end: got %b want 0", wbValid); end
    total++; if (instReady !== 1'b1) begin bad++; $display("FAIL load_ready_back: got %b want 1", instReady); end
`ifdef ALU_FLAGS_EN
    total++; if (flagZero !== model_z) begin bad++; $display("FAIL load_flagzero: got %b want %b", flagZero, model_z); end
    total++; if (flagCarry !== model_c) begin bad++; $display("FAIL load_flagcarry: got %b want %b", flagCarry, model_c); end
`endif
  endtask

  task automatic do_op(input logic [2:0] op, input logic [1:0] d, input logic [1:0] a, input logic [1:0] b);
    bit ok;
    logic [3:0] va, vb, e;
    wait_ready(ok);
    if (!ok) return;
    va = model_rf[a]; vb = model_rf[b]; e = alu_fn(va, vb, op);
    instValid = 1'b1; instLoad = 1'b0; instOp = op; instDst = d; instSrcA = a; instSrcB = b;
    instImm = 4'($urandom_range(0, 15));
    @(posedge clk); #1 instValid = 1'b0;
    @(negedge clk);
    total++; if (aluA !== va) begin bad++; $display("FAIL op_alua: got %h want %h", aluA, va); end
    total++; if (aluB !== vb) begin bad++; $display("FAIL op_alub: got %h want %h", aluB, vb); end
    total++; if (aluSel !== op) begin bad++; $display("FAIL op_alusel: got %0d want %0d", aluSel, op); end
    total++; if (instReady !== 1'b0 || wbValid !== 1'b0) begin bad++; $display("FAIL op_issue_phase: ready=%b wb=%b want 0 0", instReady, wbValid); end
    @(negedge clk);
    total++; if (wbValid !== 1'b1) begin bad++; $display("FAIL op_wbvalid: got %b want 1", wbValid); end
    total++; if (wbDst !== d) begin bad++; $display("FAIL op_wbdst: got %0d want %0d", wbDst, d); end
    total++; if (wbData !== e) begin bad++; $display("FAIL op_wbdata: op=%0d got %h want %h", op, wbData, e); end
    total++; if (instReady !== 1'b0) begin bad++; $display("FAIL op_ready_wb: got %b want 0", instReady); end
    model_rf[d] = e;
    model_op_flags(op, va, vb, e);
    @(negedge clk);
    total++; if (wbValid !== 1'b0 || instReady !== 1'b1) begin bad++; $display("FAIL op_done: wb=%b ready=%b want 0 1", wbValid, instReady); end
`ifdef ALU_FLAGS_EN
    total++; if (flagZero !== model_z) begin bad++; $display("FAIL op_flagzero: got %b want %b", flagZero, model_z); end
    total++; if (flagCarry !== model_c) begin bad++; $display("FAIL op_flagcarry: got %b want %b", flagCarry, model_c); end
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    instValid = 1'b0; instLoad = 1'b0; instOp = '0; instDst = '0; instSrcA = '0; instSrcB = '0; instImm = '0;
    for (int i = 0; i < 4; i++) model_rf[i] = 4'd0;
    model_z = 1'b0; model_c = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (wbValid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_ctrl: wb=%b busy=%b want 0 0", wbValid, busy); end
    total++; if (aluA !== 4'd0 || aluB !== 4'd0 || aluSel !== 3'd0) begin bad++; $display("FAIL reset_alu: a=%h b=%h sel=%0d want 0", aluA, aluB, aluSel); end
    total++; if (wbData !== 4'd0 || wbDst !== 2'd0) begin bad++; $display("FAIL reset_wb: data=%h dst=%0d want 0", wbData, wbDst); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (instReady !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", instReady); end
`ifdef ALU_FLAGS_EN
    total++; if (flagZero !== 1'b0 || flagCarry !== 1'b0) begin bad++; $display("FAIL reset_flags: z=%b c=%b want 0 0", flagZero, flagCarry); end
`endif
  endtask

  task automatic test_directed_alu();
    do_load(2'd0, 4'd5);
    do_load(2'd1, 4'd3);
    do_op(3'd0, 2'd2, 2'd0, 2'd1);
    total++; if (model_rf[2] !== 4'd8 || wbData !== 4'd8) begin bad++; $display("FAIL add_const: got %h want 8", wbData); end
    do_op(3'd1, 2'd3, 2'd1, 2'd0);
    total++; if (wbData !== 4'hE) begin bad++; $display("FAIL sub_wrap: got %h want e", wbData); end
    do_op(3'd7, 2'd3, 2'd0, 2'd1);
    total++; if (wbData !== 4'd1) begin bad++; $display("FAIL cmp_gt: got %h want 1", wbData); end
    do_op(3'd6, 2'd3, 2'd1, 2'd1);
    total++; if (wbData !== 4'h8) begin bad++; $display("FAIL shl_self: got %h want 8", wbData); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0)
        do_load(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      else
        do_op(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit rdy;
    int accepts = 0;
    int wbs = 0;
    int acc_cyc [2];
    logic [3:0] e, got_e;
    logic [1:0] got_d;
    wait_ready(ok);
    if (!ok) return;
    e = alu_fn(model_rf[0], model_rf[1], 3'd0);
    model_op_flags(3'd0, model_rf[0], model_rf[1], e);
    model_rf[2] = e; exp_q.push_back(e); dst_q.push_back(2'd2);
    e = alu_fn(model_rf[2], model_rf[2], 3'd0);
    model_op_flags(3'd0, model_rf[2], model_rf[2], e);
    model_rf[3] = e; exp_q.push_back(e); dst_q.push_back(2'd3);
    instValid = 1'b1; instLoad = 1'b0; instOp = 3'd0; instDst = 2'd2; instSrcA = 2'd0; instSrcB = 2'd1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      rdy = instReady;
      @(posedge clk); #1;
      if (rdy && instValid) begin
        if (accepts < 2) acc_cyc[accepts] = cyc;
        accepts++;
        if (accepts == 1) begin instDst = 2'd3; instSrcA = 2'd2; instSrcB = 2'd2; end
        else instValid = 1'b0;
      end
      @(negedge clk);
      if (wbValid === 1'b1) begin
        wbs++;
        if (exp_q.size() == 0) begin
          total++; bad++; $display("FAIL b2b_extra_wb: dst=%0d data=%h with nothing expected", wbDst, wbData);
        end else begin
          got_e = exp_q.pop_front(); got_d = dst_q.pop_front();
          total++; if (wbData !== got_e || wbDst !== got_d) begin bad++; $display("FAIL b2b_wb: got %0d/%h want %0d/%h", wbDst, wbData, got_d, got_e); end
        end
      end
    end
    instValid = 1'b0;
    total++; if (accepts != 2) begin bad++; $display("FAIL b2b_accepts: got %0d want 2", accepts); end
    total++; if (wbs != 2) begin bad++; $display("FAIL b2b_wbs: got %0d want 2", wbs); end
    if (accepts == 2) begin
      total++; if (acc_cyc[1] - acc_cyc[0] != 3) begin bad++; $display("FAIL b2b_spacing: got %0d want 3", acc_cyc[1] - acc_cyc[0]); end
    end
    exp_q.delete(); dst_q.delete();
`ifdef ALU_FLAGS_EN
    total++; if (flagZero !== model_z || flagCarry !== model_c) begin bad++; $display("FAIL b2b_flags: got %b%b want %b%b", flagZero, flagCarry, model_z, model_c); end
`endif
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_load(2'd0, 4'd5);
    do_load(2'd1, 4'd3);
    wait_ready(ok);
    if (!ok) return;
    instValid = 1'b1; instLoad = 1'b0; instOp = 3'd0; instDst = 2'd2; instSrcA = 2'd0; instSrcB = 2'd1;
    @(posedge clk); #1 instValid = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || wbValid !== 1'b0) begin bad++; $display("FAIL mid_async: busy=%b wb=%b want 0 0", busy, wbValid); end
    for (int i = 0; i < 4; i++) model_rf[i] = 4'd0;
    model_z = 1'b0; model_c = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (wbValid !== 1'b0) begin bad++; $display("FAIL mid_no_wb: got %b want 0", wbValid); end
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (wbValid !== 1'b0) begin bad++; $display("FAIL mid_no_wb_after: got %b want 0", wbValid); end
    do_op(3'd0, 2'd0, 2'd1, 2'd2);
    total++; if (wbData !== 4'd0) begin bad++; $display("FAIL mid_cleared: got %h want 0", wbData); end
  endtask

`ifdef ALU_FLAGS_EN
  task automatic test_flags();
    do_load(2'd0, 4'hF);
    do_load(2'd1, 4'h1);
    do_op(3'd0, 2'd2, 2'd0, 2'd1);
    total++; if (flagZero !== 1'b1 || flagCarry !== 1'b1) begin bad++; $display("FAIL flags_add_wrap: got %b%b want 11", flagZero, flagCarry); end
    do_load(2'd3, 4'h2);
    total++; if (flagZero !== 1'b0 || flagCarry !== 1'b1) begin bad++; $display("FAIL flags_after_load: got %b%b want 01", flagZero, flagCarry); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed_alu();
    test_random();
    test_back_to_back();
    test_reset_mid();
`ifdef ALU_FLAGS_EN
    test_flags();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
